// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshakes around the unified memory port.
// The master modport is the arbiter's view; slave is the pipeline/memory environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  grant_if;
  logic                  grant_d;
  logic                  bus_error;

  modport master (
    input  if_req, if_addr,
    output if_ready, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ready, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output grant_if, grant_d, bus_error
  );

  modport slave (
    output if_req, if_addr,
    input  if_ready, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ready, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  grant_if, grant_d, bus_error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store: data-first
// priority, bounded fetch starvation, and a watchdog that aborts hung transactions.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.master  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_D  = 2'd2;

  localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam int WW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT_CYCLES - 1);

  logic [1:0]            r_state;
  logic [SW-1:0]         r_streak;
  logic [WW-1:0]         r_wdog;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_bus_error;

  logic                  w_idle;
  logic                  w_busy;
  logic                  w_streak_full;
  logic                  w_grant_d;
  logic                  w_grant_if;
  logic                  w_timeout;
  logic                  w_done;
  logic                  w_if_ready;
  logic                  w_d_ready;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [SW-1:0]         w_streak_inc;

  assign w_idle        = (r_state == S_IDLE);
  assign w_busy        = (r_state == S_BUSY_IF) || (r_state == S_BUSY_D);
  assign w_streak_full = (r_streak == STREAK_MAX);

  // A waiting fetch overrides data priority once the data streak has saturated.
  assign w_grant_d  = w_idle && bus.d_req && !(bus.if_req && w_streak_full);
  assign w_grant_if = w_idle && !w_grant_d && bus.if_req;

  assign w_timeout = w_busy && !bus.mem_ready && (r_wdog == WDOG_LAST);
  // Reset suppresses the completion pulse of a transaction that is being killed.
  assign w_done    = w_busy && (bus.mem_ready || w_timeout) && !reset;

  assign w_rdata      = bus.mem_ready ? bus.mem_rdata : '0;
  assign w_streak_inc = w_streak_full ? r_streak : r_streak + 1'b1;

  assign w_if_ready = (r_state == S_BUSY_IF) && w_done;
  assign w_d_ready  = (r_state == S_BUSY_D) && w_done;

  assign bus.if_ready  = w_if_ready;
  assign bus.if_rdata  = w_if_ready ? w_rdata : '0;
  assign bus.d_ready   = w_d_ready;
  assign bus.d_rdata   = w_d_ready ? w_rdata : '0;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.grant_if  = (r_state == S_BUSY_IF);
  assign bus.grant_d   = (r_state == S_BUSY_D);
  assign bus.bus_error = r_bus_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_streak    <= '0;
      r_wdog      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_bus_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state     <= S_BUSY_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_wdog      <= '0;
            r_streak    <= bus.if_req ? w_streak_inc : '0;
          end else if (w_grant_if) begin
            r_state     <= S_BUSY_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
            r_wdog      <= '0;
            r_streak    <= '0;
          end
        end
        S_BUSY_IF, S_BUSY_D: begin
          if (w_done) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            if (w_timeout) begin
              r_bus_error <= 1'b1;
            end
          end else if (!bus.mem_ready) begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences one memory transaction at a time through a req/ready handshake.
- Gives data accesses priority, with an anti-starvation guard for fetch and a watchdog that ends hung transactions.
- Sits between the pipeline stages and the memory; the pipeline uses the per-requester ready signals to stall.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
MAX_DATA_STREAK, 4, back-to-back data grants allowed while a fetch is waiting; must be at least 1
TIMEOUT_CYCLES, 64, busy cycles without mem_ready before the transaction is aborted; must be at least 2

Ports:
clock  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high until if_ready
if_addr  in  ADDR_WIDTH  fetch address
if_ready  out  1  one-cycle completion pulse for the fetch
if_rdata  out  DATA_WIDTH  fetched word, valid while if_ready is high
d_req  in  1  data request; held high until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_ready  out  1  one-cycle completion pulse for the data access
d_rdata  out  DATA_WIDTH  load data, valid while d_ready is high
mem_req  out  1  memory request, held high until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_ready  in  1  memory completion; only meaningful while mem_req is high
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
grant_if  out  1  state is BUSY_IF
grant_d  out  1  state is BUSY_D
bus_error  out  1  sticky flag: a watchdog timeout has occurred

Behaviour:
- Reset values: state IDLE; every output 0, including mem_addr and mem_wdata; streak and watchdog counters 0; bus_error 0. The reset value wins over any other event in the same cycle.
- States:
  - IDLE: no transaction in flight.
  - BUSY_IF: fetch transaction in flight.
  - BUSY_D: data transaction in flight.
- Arbitration, evaluated in IDLE at the clock edge:
  - d_req and not (if_req and streak == MAX_DATA_STREAK) -> go to BUSY_D.
  - else if_req -> go to BUSY_IF.
  - else stay in IDLE.
- On a grant, all of the following are registered on that edge: mem_req = 1, mem_addr, mem_we (d_we for data, 0 for fetch), mem_wdata (d_wdata for data, 0 for fetch), and the watchdog cleared to 0.
  - Request cycle 0 -> mem_req high in cycle 1.
- In BUSY_x:
  - mem_req stays high; mem_addr, mem_we and mem_wdata stay stable.
  - Combinational completion: x_ready = mem_ready, and x_rdata = mem_rdata. The other requester's ready is 0, and both rdata outputs are 0 whenever the matching ready is 0.
  - The edge that sees mem_ready drops mem_req and returns to IDLE.
  - Minimum request-to-ready latency is 1 cycle; back-to-back grants are separated by at least one IDLE cycle.
- Requester rule: deassert req, or present a new request, in the cycle after ready. A request held longer is re-granted as a new transaction.
- Streak counter, saturating at MAX_DATA_STREAK:
  - Data grant while if_req is high -> +1.
  - Data grant while if_req is low -> reset to 0.
  - Any fetch grant -> reset to 0.
  - Result: a waiting fetch is granted after at most MAX_DATA_STREAK data grants.
- Watchdog:
  - Increments each BUSY cycle in which mem_ready is low.
  - When it reaches TIMEOUT_CYCLES - 1 and mem_ready is still low, the block pulses x_ready with x_rdata = 0, sets bus_error, drops mem_req and returns to IDLE.
  - An aborted store is discarded. bus_error is cleared only by reset.
  - mem_ready arriving in the abort cycle is a normal completion: real data is returned and bus_error is not set.
- mem_ready seen in IDLE is ignored.
- Reset during BUSY: mem_req drops on that edge and no ready pulse is generated; the memory must tolerate the dropped request.
- Requester address and data changes while not granted have no effect.

Test Plan:
- Single fetch: if_req=1, if_addr=0x40, memory returns 0x2002000A one cycle after mem_req -> mem_req in cycle 1, if_ready=1 with if_rdata=0x2002000A in cycle 2, grant_d never asserted.
- Simultaneous if_req and d_req (load, d_addr=0x100) -> data granted first (grant_d=1, mem_we=0, mem_addr=0x100), then fetch granted after one IDLE cycle.
- Store: d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF held until mem_ready; d_ready pulses exactly 1 cycle.
- Starvation guard: d_req and if_req held continuously, MAX_DATA_STREAK=4 -> grant sequence D,D,D,D,IF,D,...
- Timeout: mem_ready tied 0, TIMEOUT_CYCLES=64 -> after 64 busy cycles d_ready=1 with d_rdata=0, bus_error=1 (sticky), mem_req=0; a subsequent fetch completes normally.
- Reset mid-transaction: reset asserted in cycle 2 of BUSY_D -> next edge: mem_req=0, state IDLE, no d_ready pulse, bus_error=0.
